// File: rtl/mc_control_unit.sv
// Audio playback control unit: APB register file, per-channel sample FIFOs, STANDBY/PLAY sequencing, refill IRQ.
// Register updates, command pulses and ticks land one cycle after their cause; the APB side never stalls.
module mc_control_unit #(
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int DSP_REGS   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [31:0]            PADDR,
    input  logic [31:0]            PWDATA,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    input  logic                   req_in,
    output logic                   tick_out,
    output logic                   play_out,
    output logic                   irq_out,
    output logic                   cfg_out,
    output logic                   clr_out,
    output logic                   level_out,
    output logic [31:0]            cfg_reg_out,
    output logic [31:0]            level_reg_out,
    output logic [31:0]            wmark_reg_out,
    output logic [DSP_REGS*32-1:0] dsp_regs_out,
    output logic [CHANNELS*24-1:0] audio_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {STANDBY = 1'b0, PLAY = 1'b1} state_t;
    state_t state_q, state_d;

    logic                wr_acc, rd_acc, cmd_wr;
    logic                cmd_clr, cmd_cfg, cmd_start, cmd_stop, cmd_level, cmd_irqack;
    logic                tick_q, irq_q, udr_q, ovf_q;
    logic [CHANNELS-1:0] push, full, empty, do_push, do_pop;
    logic [AW-1:0]       wp      [CHANNELS];
    logic [AW-1:0]       rp      [CHANNELS];
    logic [CW-1:0]       cnt     [CHANNELS];
    logic [CW-1:0]       cnt_nxt [CHANNELS];
    logic [23:0]         mem     [CHANNELS][FIFO_DEPTH];
    logic [31:0]         status;

    assign PREADY     = 1'b1;
    assign PSLVERR    = 1'b0;
    assign wr_acc     = PSEL & PENABLE & PWRITE;
    assign rd_acc     = PSEL & PENABLE & ~PWRITE;
    assign cmd_wr     = wr_acc && (PADDR == 32'h0);
    assign cmd_clr    = cmd_wr && (PWDATA == 32'd1);
    assign cmd_cfg    = cmd_wr && (PWDATA == 32'd2);
    assign cmd_start  = cmd_wr && (PWDATA == 32'd3);
    assign cmd_stop   = cmd_wr && (PWDATA == 32'd4);
    assign cmd_level  = cmd_wr && (PWDATA == 32'd5);
    assign cmd_irqack = cmd_wr && (PWDATA == 32'd6);

    assign play_out = (state_q == PLAY);
    assign irq_out  = irq_q & play_out;
    assign tick_out = tick_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            STANDBY: if (cmd_start) state_d = PLAY;
            PLAY:    if (cmd_stop)  state_d = STANDBY;
            default: state_d = STANDBY;
        endcase
    end

    // A full FIFO still accepts a push when the same edge pops it.
    always_comb begin
        push    = '0;
        full    = '0;
        empty   = '0;
        do_push = '0;
        do_pop  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            push[c]    = wr_acc && (PADDR == 32'h20 + 32'(4 * c));
            full[c]    = (cnt[c] == CW'(FIFO_DEPTH));
            empty[c]   = (cnt[c] == '0);
            do_push[c] = push[c] && (!full[c] || tick_q);
            do_pop[c]  = tick_q && !empty[c];
            cnt_nxt[c] = cnt[c] + CW'(do_push[c]) - CW'(do_pop[c]);
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (do_push[c]) mem[c][wp[c]] <= PWDATA[23:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wp[c]  <= '0;
                rp[c]  <= '0;
                cnt[c] <= '0;
            end
            audio_out <= '0;
        end else if (cmd_clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wp[c]  <= '0;
                rp[c]  <= '0;
                cnt[c] <= '0;
            end
            audio_out <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (do_push[c]) wp[c] <= wp[c] + AW'(1);
                if (do_pop[c])  rp[c] <= rp[c] + AW'(1);
                if (tick_q)     audio_out[24*c +: 24] <= empty[c] ? 24'h0 : mem[c][rp[c]];
                cnt[c] <= cnt_nxt[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STANDBY;
            tick_q    <= 1'b0;
            irq_q     <= 1'b0;
            udr_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cfg_out   <= 1'b0;
            clr_out   <= 1'b0;
            level_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            // A tick is only issued if PLAY survives this edge, so tick_out never shows in STANDBY.
            tick_q    <= req_in && (state_q == PLAY) && (state_d == PLAY);
            cfg_out   <= cmd_cfg && (state_q == STANDBY);
            clr_out   <= cmd_clr;
            level_out <= cmd_level;
            if (cmd_clr) begin
                udr_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                if (tick_q && (|empty)) udr_q <= 1'b1;
                if (|(push & full & ~{CHANNELS{tick_q}})) ovf_q <= 1'b1;
            end
            if (cmd_irqack || cmd_stop || cmd_clr) begin
                irq_q <= 1'b0;
            end else if (tick_q && (state_q == PLAY) &&
                         (32'(cnt_nxt[0]) <= 32'(wmark_reg_out[7:0]))) begin
                irq_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg_out   <= '0;
            level_reg_out <= '0;
            wmark_reg_out <= '0;
            dsp_regs_out  <= '0;
        end else if (wr_acc) begin
            case (PADDR)
                32'h08:  cfg_reg_out   <= PWDATA;
                32'h0C:  level_reg_out <= PWDATA;
                32'h10:  wmark_reg_out <= PWDATA;
                default: begin
                    for (int i = 0; i < DSP_REGS; i++) begin
                        if (PADDR == 32'h40 + 32'(4 * i)) dsp_regs_out[32*i +: 32] <= PWDATA;
                    end
                end
            endcase
        end
    end

    always_comb begin
        status    = '0;
        status[0] = play_out;
        status[1] = irq_out;
        status[2] = udr_q;
        status[3] = ovf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            status[4 + c]  = empty[c];
            status[12 + c] = full[c];
        end
        status[31:20] = 12'(cnt[0]);

        PRDATA = '0;
        if (rd_acc && rst_n) begin
            case (PADDR)
                32'h04:  PRDATA = status;
                32'h08:  PRDATA = cfg_reg_out;
                32'h0C:  PRDATA = level_reg_out;
                32'h10:  PRDATA = wmark_reg_out;
                default: begin
                    for (int i = 0; i < DSP_REGS; i++) begin
                        if (PADDR == 32'h40 + 32'(4 * i)) PRDATA = dsp_regs_out[32*i +: 32];
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized scoreboard bench for mc_control_unit against a queue-based behavioural model.
// Stimulus pushes expected read data and audio frames; a negedge monitor pops and compares them.
module tb_mc_control_unit;
    localparam int CH    = 2;
    localparam int DEPTH = 16;
    localparam int NDSP  = 8;
    localparam logic [31:0] A_CMD  = 32'h00;
    localparam logic [31:0] A_STAT = 32'h04;
    localparam logic [31:0] A_CFG  = 32'h08;
    localparam logic [31:0] A_LVL  = 32'h0C;
    localparam logic [31:0] A_WM   = 32'h10;
    localparam logic [31:0] A_FIFO = 32'h20;
    localparam logic [31:0] A_DSP  = 32'h40;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0, req_in = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] PRDATA;
    logic PREADY, PSLVERR, tick_out, play_out, irq_out, cfg_out, clr_out, level_out;
    logic [31:0] cfg_reg_out, level_reg_out, wmark_reg_out;
    logic [NDSP*32-1:0] dsp_regs_out;
    logic [CH*24-1:0] audio_out;

    mc_control_unit #(.CHANNELS(CH), .FIFO_DEPTH(DEPTH), .DSP_REGS(NDSP)) dut (
        .clk(clk), .rst_n(rst_n),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .req_in(req_in), .tick_out(tick_out), .play_out(play_out), .irq_out(irq_out),
        .cfg_out(cfg_out), .clr_out(clr_out), .level_out(level_out),
        .cfg_reg_out(cfg_reg_out), .level_reg_out(level_reg_out), .wmark_reg_out(wmark_reg_out),
        .dsp_regs_out(dsp_regs_out), .audio_out(audio_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model
    logic [23:0]        mq [CH][$];
    bit                 m_play, m_irq, m_udr, m_ovf;
    logic [31:0]        m_cfg, m_lvl, m_wm;
    logic [NDSP*32-1:0] m_dsp;
    logic [CH*24-1:0]   m_audio;
    logic [31:0]        rd_q [$];
    logic [CH*24-1:0]   aud_q [$];

    task automatic mdl_reset();
        for (int c = 0; c < CH; c++) mq[c].delete();
        m_play = 0; m_irq = 0; m_udr = 0; m_ovf = 0;
        m_cfg = '0; m_lvl = '0; m_wm = '0; m_dsp = '0; m_audio = '0;
    endtask

    function automatic bit is_dsp(input logic [31:0] a);
        return (a >= A_DSP) && (a < A_DSP + 32'(4 * NDSP)) && (a[1:0] == 2'b00);
    endfunction

    function automatic bit is_fifo(input logic [31:0] a);
        return (a >= A_FIFO) && (a < A_FIFO + 32'(4 * CH)) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] mdl_status();
        logic [31:0] s;
        s = '0;
        s[0] = m_play;
        s[1] = m_irq && m_play;
        s[2] = m_udr;
        s[3] = m_ovf;
        for (int c = 0; c < CH; c++) begin
            s[4 + c]  = (mq[c].size() == 0);
            s[12 + c] = (mq[c].size() == DEPTH);
        end
        s[31:20] = 12'(mq[0].size());
        return s;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        int i;
        if (a == A_STAT) return mdl_status();
        if (a == A_CFG)  return m_cfg;
        if (a == A_LVL)  return m_lvl;
        if (a == A_WM)   return m_wm;
        if (is_dsp(a)) begin
            i = int'((a - A_DSP) >> 2);
            return m_dsp[32*i +: 32];
        end
        return '0;
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d,
                             output bit pc, output bit pcl, output bit pl);
        int i;
        pc = 0; pcl = 0; pl = 0;
        if (a == A_CMD) begin
            case (d)
                32'd1: begin
                    pcl = 1;
                    for (int c = 0; c < CH; c++) mq[c].delete();
                    m_audio = '0; m_udr = 0; m_ovf = 0; m_irq = 0;
                end
                32'd2: pc = !m_play;
                32'd3: m_play = 1;
                32'd4: begin m_play = 0; m_irq = 0; end
                32'd5: pl = 1;
                32'd6: m_irq = 0;
                default: ;
            endcase
        end else if (a == A_CFG) m_cfg = d;
        else if (a == A_LVL) m_lvl = d;
        else if (a == A_WM)  m_wm = d;
        else if (is_fifo(a)) begin
            i = int'((a - A_FIFO) >> 2);
            if (mq[i].size() == DEPTH) m_ovf = 1;
            else mq[i].push_back(d[23:0]);
        end else if (is_dsp(a)) begin
            i = int'((a - A_DSP) >> 2);
            m_dsp[32*i +: 32] = d;
        end
    endtask

    task automatic mdl_pop();
        for (int c = 0; c < CH; c++) begin
            if (mq[c].size() > 0) m_audio[24*c +: 24] = mq[c].pop_front();
            else begin
                m_audio[24*c +: 24] = '0;
                m_udr = 1;
            end
        end
        aud_q.push_back(m_audio);
    endtask

    task automatic mdl_irq_eval();
        if (mq[0].size() <= int'(m_wm[7:0])) m_irq = 1;
    endtask

    // Bus driver: inputs change 1 time unit after the rising edge
    task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic with_req);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; req_in = with_req;
        @(posedge clk); #1;
        penable = 1; req_in = 0;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bit pc, pcl, pl;
        mdl_write(a, d, pc, pcl, pl);
        bus(1'b1, a, d, 1'b0);
        if (a == A_CMD) begin
            @(negedge clk);
            chk("cfg_pulse", cfg_out, pc);
            chk("clr_pulse", clr_out, pcl);
            chk("level_pulse", level_out, pl);
            @(negedge clk);
            chk("pulse_end", {cfg_out, clr_out, level_out}, 3'b000);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        rd_q.push_back(mdl_read(a));
        bus(1'b0, a, '0, 1'b0);
    endtask

    task automatic tick();
        bit exp_t;
        exp_t = m_play;
        if (m_play) begin
            mdl_pop();
            mdl_irq_eval();
        end
        @(posedge clk); #1; req_in = 1;
        @(posedge clk); #1; req_in = 0;
        @(negedge clk);
        chk("tick_out", tick_out, exp_t);
        @(posedge clk); #1;
    endtask

    // FIFO write whose access cycle coincides with tick_out
    task automatic push_tick(input int c, input logic [23:0] d);
        bit pc, pcl, pl, was_play;
        was_play = m_play;
        if (was_play) mdl_pop();
        mdl_write(A_FIFO + 32'(4 * c), {8'h0, d}, pc, pcl, pl);
        if (was_play) mdl_irq_eval();
        bus(1'b1, A_FIFO + 32'(4 * c), {8'h0, d}, was_play);
    endtask

    task automatic post();
        @(negedge clk);
        chk("play_out", play_out, m_play);
        chk("irq_out", irq_out, m_irq && m_play);
        chk("cfg_reg_out", cfg_reg_out, m_cfg);
        chk("level_reg_out", level_reg_out, m_lvl);
        chk("wmark_reg_out", wmark_reg_out, m_wm);
        chk("dsp_regs_out", dsp_regs_out, m_dsp);
        chk("audio_out", audio_out, m_audio);
    endtask

    // Monitor: audio frame follows each tick by one cycle; read data checked on every read access
    bit aud_pend = 0;
    always @(negedge clk) begin
        if (aud_pend) begin
            if (aud_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL audio_frame: got 0x%0h, expected no frame", audio_out);
            end else chk("audio_frame", audio_out, aud_q.pop_front());
        end
        aud_pend = (tick_out === 1'b1);
        if (tick_out === 1'b1) chk("tick_expected", 256'(aud_q.size() != 0), 256'(1));
        if (psel && penable && !pwrite) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL prdata: got 0x%0h, expected no read", PRDATA);
            end else chk("prdata", PRDATA, rd_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {tick_out, play_out, irq_out, cfg_out, clr_out, level_out}, 6'b0);
        chk({tag, "_regs"}, {cfg_reg_out, level_reg_out, wmark_reg_out}, 96'h0);
        chk({tag, "_dsp"}, dsp_regs_out, '0);
        chk({tag, "_audio"}, audio_out, '0);
        chk({tag, "_apb"}, {PRDATA, PREADY, PSLVERR}, {32'h0, 1'b1, 1'b0});
    endtask

    int cmds [10] = '{1, 2, 3, 3, 3, 4, 5, 6, 0, 7};
    logic [31:0] wr_tab [8] = '{32'h08, 32'h0C, 32'h10, 32'h40, 32'h5C, 32'h14, 32'h28, 32'h04};
    logic [31:0] rd_tab [12] = '{32'h00, 32'h04, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20,
                                 32'h24, 32'h44, 32'h58, 32'h60, 32'h14};

    initial begin
        mdl_reset();
        #1 rst_n = 0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        post();
        rd(A_STAT);
        post();

        // CFG command only honoured in STANDBY
        wr(A_CFG, 32'h5); post();
        wr(A_CMD, 32'd2); post();
        wr(A_CMD, 32'd3); post();
        wr(A_CMD, 32'd2); post();

        // First-sample path
        wr(A_CMD, 32'd4); wr(A_CMD, 32'd1);
        wr(A_FIFO, 32'h111111); wr(A_FIFO + 4, 32'h222222);
        wr(A_CMD, 32'd3);
        tick(); post();
        chk("first_frame", audio_out, 48'h222222_111111);

        // Overflow on the 17th push
        wr(A_CMD, 32'd4); wr(A_CMD, 32'd1);
        for (int k = 0; k < DEPTH; k++) wr(A_FIFO, 32'(k + 32'h100));
        rd(A_STAT);
        wr(A_FIFO, 32'h0ABCDE);
        rd(A_STAT); post();

        // Push into a full FIFO on the same edge as a pop
        wr(A_CMD, 32'd1);
        for (int k = 0; k < DEPTH; k++) wr(A_FIFO, 32'(k + 32'h200));
        wr(A_CMD, 32'd3);
        push_tick(0, 24'hABCDEF);
        rd(A_STAT); post();

        // Refill interrupt at watermark
        wr(A_CMD, 32'd4); wr(A_CMD, 32'd1);
        wr(A_WM, 32'h2);
        for (int k = 0; k < 4; k++) begin
            wr(A_FIFO, 32'(k + 32'h300));
            wr(A_FIFO + 4, 32'(k + 32'h400));
        end
        wr(A_CMD, 32'd3);
        tick(); post();
        tick(); post();
        wr(A_CMD, 32'd6); post();

        // Underrun on empty FIFOs, cleared by CLR
        wr(A_CMD, 32'd4); wr(A_CMD, 32'd1); wr(A_CMD, 32'd3);
        tick(); post();
        rd(A_STAT);
        wr(A_CMD, 32'd1);
        rd(A_STAT); post();

        // Non-readable and DSP addresses
        wr(A_CMD, 32'd4);
        rd(A_CMD); rd(A_FIFO); rd(32'h14);
        wr(A_DSP + 4, 32'hDEADBEEF); rd(A_DSP + 4); post();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [31:0] d;
            op = int'($urandom_range(0, 99));
            d  = $urandom;
            if (op < 40) wr(A_FIFO + 32'(4 * $urandom_range(0, CH - 1)), d);
            else if (op < 62) tick();
            else if (op < 77) wr(A_CMD, 32'(cmds[$urandom_range(0, 9)]));
            else if (op < 87) begin
                logic [31:0] a;
                a = wr_tab[$urandom_range(0, 7)];
                if (a == A_WM) d[7:0] = 8'($urandom_range(0, 10));
                wr(a, d);
            end else rd(rd_tab[$urandom_range(0, 11)]);
            post();
        end

        // Reset in the middle of PLAY
        wr(A_CMD, 32'd1);
        for (int k = 0; k < 3; k++) wr(A_FIFO, 32'(k + 32'h500));
        wr(A_CMD, 32'd3);
        tick(); post();
        @(posedge clk); #1 rst_n = 0;
        #1 chk_reset_outputs("midplay_reset");
        mdl_reset();
        @(posedge clk); #1 rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_reset_quiet", {tick_out, cfg_out, clr_out, level_out, irq_out, play_out}, 6'b0);
        end
        rd(A_STAT); post();
        tick(); post();

        @(negedge clk);
        chk("audio_queue_drained", 256'(aud_q.size()), 256'(0));
        chk("read_queue_drained", 256'(rd_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
